// File: rtl/vga_line_plotter_if.sv
// rtl/vga_line_plotter_if.sv - request/pixel-write bundle for the line plotter
//
// Ports (signals):
//   start      request strobe, only honoured while the plotter is idle
//   x0,y0      first endpoint;  x1,y1  second endpoint
//   colour_in  colour for the whole line
//   x,y        current pixel;  colour  latched line colour
//   plot       pixel write strobe;  busy  line in progress;  done  completion pulse
// Modports: master = requester side, slave = plotter side.
interface vga_line_plotter_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 6
) ();
  logic          start;
  logic [XW-1:0] x0;
  logic [XW-1:0] x1;
  logic [YW-1:0] y0;
  logic [YW-1:0] y1;
  logic [CW-1:0] colour_in;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot;
  logic          busy;
  logic          done;

  modport master (
    output start, x0, x1, y0, y1, colour_in,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, x0, x1, y0, y1, colour_in,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/vga_line_plotter.sv
// rtl/vga_line_plotter.sv - Bresenham line walker emitting one framebuffer write per clock
//
// Ports:
//   vga_clock  system clock, rising edge
//   reset      synchronous active-high reset
//   bus        vga_line_plotter_if.slave: line request in, pixel writes out
module vga_line_plotter #(
  parameter string RESOLUTION              = "160x120",
  parameter int    BITS_PER_COLOUR_CHANNEL = 2,
  parameter string MONOCHROME              = "FALSE"
) (
  input  logic              vga_clock,
  input  logic              reset,
  vga_line_plotter_if.slave bus
);

  localparam bit HIRES = (RESOLUTION == "320x240");
  localparam int XW    = HIRES ? 9 : 8;
  localparam int YW    = HIRES ? 8 : 7;
  localparam int XMAX  = HIRES ? 320 : 160;
  localparam int YMAX  = HIRES ? 240 : 120;
  localparam int CW    = (MONOCHROME == "TRUE") ? 1 : 3 * BITS_PER_COLOUR_CHANNEL;
  // Error term width: |dx| needs XW bits, plus sign, plus headroom for dx+dy.
  localparam int EW    = XW + 2;

  localparam logic [XW-1:0]        XLIM = XW'(XMAX);
  localparam logic [YW-1:0]        YLIM = YW'(YMAX);
  localparam logic signed [EW-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_DRAW,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         x0_q, x0_d, x1_q, x1_d;
  logic [YW-1:0]         y0_q, y0_d, y1_q, y1_d;
  logic [CW-1:0]         colour_q, colour_d;
  logic signed [EW-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                  sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic [XW-1:0]         cx_q, cx_d;
  logic [YW-1:0]         cy_q, cy_d;

  logic [XW-1:0]         adx;
  logic [YW-1:0]         ady;
  logic signed [EW-1:0]  adx_e, ady_e;
  logic signed [EW:0]    e2, dx_w, dy_w;
  logic                  step_x, step_y, at_end;

  // Absolute endpoint deltas, computed from the latched request.
  assign adx   = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
  assign ady   = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
  assign adx_e = $signed({2'b00, adx});
  assign ady_e = $signed({{(EW - YW){1'b0}}, ady});

  // e2 = 2*err, one bit wider so the doubling never wraps.
  assign e2     = $signed({err_q, 1'b0});
  assign dx_w   = $signed({dx_q[EW-1], dx_q});
  assign dy_w   = $signed({dy_q[EW-1], dy_q});
  assign step_x = (e2 >= dy_w);
  assign step_y = (e2 <= dx_w);
  assign at_end = (cx_q == x1_q) && (cy_q == y1_q);

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      colour_q <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      colour_q <= colour_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    colour_d = colour_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    cx_d     = cx_q;
    cy_d     = cy_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x0_d     = bus.x0;
          x1_d     = bus.x1;
          y0_d     = bus.y0;
          y1_d     = bus.y1;
          colour_d = bus.colour_in;
          state_d  = S_INIT;
        end
      end
      S_INIT: begin
        dx_d     = adx_e;
        dy_d     = -ady_e;
        err_d    = adx_e - ady_e;
        // Equal coordinates step "negative", but then that axis never moves.
        sx_neg_d = !(x0_q < x1_q);
        sy_neg_d = !(y0_q < y1_q);
        cx_d     = x0_q;
        cy_d     = y0_q;
        state_d  = S_DRAW;
      end
      S_DRAW: begin
        if (at_end) begin
          state_d = S_DONE;
        end else begin
          // Both axis decisions use the error value from the start of the cycle.
          err_d = err_q + (step_x ? dy_q : ZERO) + (step_y ? dx_q : ZERO);
          if (step_x) cx_d = sx_neg_q ? (cx_q - 1'b1) : (cx_q + 1'b1);
          if (step_y) cy_d = sy_neg_q ? (cy_q - 1'b1) : (cy_q + 1'b1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The current point register doubles as the pixel output, so x/y hold
  // their last value whenever no write is being issued.
  assign bus.x      = cx_q;
  assign bus.y      = cy_q;
  assign bus.colour = colour_q;
  assign bus.plot   = (state_q == S_DRAW) && (cx_q < XLIM) && (cy_q < YLIM);
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);

endmodule

// File: tb/tb_vga_line_plotter.sv
// tb/tb_vga_line_plotter.sv - randomized bench for vga_line_plotter with per-cycle reference schedule
module tb_vga_line_plotter;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int CW   = 6;
  localparam int XMAX = 160;
  localparam int YMAX = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_line_plotter_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

  vga_line_plotter #(
    .RESOLUTION              ("160x120"),
    .BITS_PER_COLOUR_CHANNEL (2),
    .MONOCHROME              ("FALSE")
  ) dut (
    .vga_clock (clk),
    .reset     (rst),
    .bus       (bus)
  );

  typedef struct {
    bit plot;
    bit busy;
    bit done;
    bit chk_xy;
    bit chk_col;
    int x;
    int y;
    int col;
  } exp_t;

  exp_t exp_tab[int];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;
  int   last_x  = 0;
  int   last_y  = 0;
  int   cur_len = 0;
  int   px[$];
  int   py[$];

  function automatic exp_t reset_rec();
    exp_t e;
    e = '{plot:0, busy:0, done:0, chk_xy:1, chk_col:1, x:0, y:0, col:0};
    return e;
  endfunction

  function automatic void check_int(string name, int act, int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endfunction

  // Reference point list of the line, straight from the error-term rules.
  function automatic void build_pts(int x0, int y0, int x1, int y1);
    int dx, dy, sx, sy, err, e2, cx, cy;
    px.delete();
    py.delete();
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    cx  = x0;
    cy  = y0;
    for (int n = 0; n < 1024; n++) begin
      px.push_back(cx);
      py.push_back(cy);
      if (cx == x1 && cy == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endfunction

  // Expected outputs: INIT at label m, DRAW points at m+1.., DONE right after.
  function automatic void schedule(int m, int x0, int y0, int x1, int y1, int col);
    int len;
    build_pts(x0, y0, x1, y1);
    len = px.size();
    exp_tab[m] = '{plot:0, busy:1, done:0, chk_xy:1, chk_col:0, x:last_x, y:last_y, col:0};
    for (int i = 0; i < len; i++) begin
      exp_tab[m + 1 + i] = '{plot:(px[i] < XMAX && py[i] < YMAX), busy:1, done:0,
                             chk_xy:1, chk_col:1, x:px[i], y:py[i], col:col};
    end
    exp_tab[m + 1 + len] = '{plot:0, busy:1, done:1, chk_xy:1, chk_col:1, x:x1, y:y1, col:col};
    last_x  = x1;
    last_y  = y1;
    cur_len = len;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   bad;
    if (chk_en) begin
      e = '{plot:0, busy:0, done:0, chk_xy:0, chk_col:0, x:0, y:0, col:0};
      if (exp_tab.exists(cyc)) e = exp_tab[cyc];
      bad = (bus.plot !== e.plot) || (bus.busy !== e.busy) || (bus.done !== e.done);
      if (e.chk_xy && ((bus.x !== XW'(e.x)) || (bus.y !== YW'(e.y)))) bad = 1'b1;
      if (e.chk_col && (bus.colour !== CW'(e.col))) bad = 1'b1;
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL cycle %0d: got plot=%b busy=%b done=%b x=%0d y=%0d col=%h; want plot=%b busy=%b done=%b x=%0d y=%0d col=%h",
                 cyc, bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour,
                 e.plot, e.busy, e.done, e.x, e.y, e.col);
      end
    end
    cyc++;
  end

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    bus.x0        = XW'($urandom);
    bus.x1        = XW'($urandom);
    bus.y0        = YW'($urandom);
    bus.y1        = YW'($urandom);
    bus.colour_in = CW'($urandom);
  endtask

  // Caller must be just after a sync with the DUT idle in the previous label.
  task automatic run_line(int x0, int y0, int x1, int y1, int col,
                          int gap, bit mid_start, int rst_at);
    int m, len, target, r;
    m             = cyc;
    bus.x0        = XW'(x0);
    bus.y0        = YW'(y0);
    bus.x1        = XW'(x1);
    bus.y1        = YW'(y1);
    bus.colour_in = CW'(col);
    bus.start     = 1'b1;
    schedule(m, x0, y0, x1, y1, col);
    len = cur_len;
    sync();
    bus.start = 1'b0;
    scramble_inputs();
    if (mid_start) begin
      sync();
      scramble_inputs();
      bus.start = 1'b1;
      sync();
      bus.start = 1'b0;
    end
    if (rst_at > 0) begin
      while (cyc < m + rst_at + 1) sync();
      r   = cyc;
      rst = 1'b1;
      for (int k = r; k <= m + len + 2; k++) begin
        if (exp_tab.exists(k)) exp_tab.delete(k);
      end
      exp_tab[r]     = reset_rec();
      exp_tab[r + 1] = reset_rec();
      last_x = 0;
      last_y = 0;
      sync();
      rst    = 1'b0;
      target = r + 3;
    end else begin
      target = m + len + 3;
    end
    while (cyc < target + gap) sync();
  endtask

  int steep_x[6] = '{0, 0, 1, 1, 2, 2};
  int steep_y[6] = '{0, 1, 2, 3, 4, 5};

  initial begin
    int inb;
    bus.start     = 1'b0;
    bus.x0        = '0;
    bus.x1        = '0;
    bus.y0        = '0;
    bus.y1        = '0;
    bus.colour_in = '0;

    // Pin the reference model against hand-worked lines.
    build_pts(0, 0, 2, 5);
    check_int("model_steep_len", px.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check_int("model_steep_x", px[i], steep_x[i]);
      check_int("model_steep_y", py[i], steep_y[i]);
    end
    build_pts(6, 5, 2, 5);
    check_int("model_rev_len", px.size(), 5);
    check_int("model_rev_first_x", px[0], 6);
    check_int("model_rev_last_x", px[4], 2);
    build_pts(3, 9, 3, 6);
    check_int("model_vrev_len", py.size(), 4);
    check_int("model_vrev_y1", py[1], 8);
    build_pts(158, 0, 161, 0);
    inb = 0;
    foreach (px[i]) if (px[i] < XMAX) inb++;
    check_int("model_clip_len", px.size(), 4);
    check_int("model_clip_inbounds", inb, 2);
    build_pts(10, 10, 10, 10);
    check_int("model_point_len", px.size(), 1);

    sync();
    sync();
    rst = 1'b0;
    exp_tab[cyc] = reset_rec();
    chk_en = 1'b1;
    sync();

    run_line(2, 5, 6, 5, 'h30, 1, 1'b0, 0);
    run_line(0, 0, 2, 5, 'h0c, 0, 1'b0, 0);
    run_line(6, 5, 2, 5, 'h03, 0, 1'b0, 0);
    run_line(3, 9, 3, 6, 'h15, 2, 1'b0, 0);
    run_line(10, 10, 10, 10, 'h3f, 0, 1'b0, 0);
    run_line(158, 0, 161, 0, 'h2a, 1, 1'b0, 0);
    run_line(20, 30, 40, 10, 'h11, 0, 1'b1, 0);
    run_line(0, 0, 50, 20, 'h22, 0, 1'b0, 5);
    run_line(5, 5, 9, 7, 'h33, 1, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      int ax0, ay0, ax1, ay1;
      if ($urandom_range(0, 1) == 0) begin
        ax0 = $urandom_range(0, 40);
        ay0 = $urandom_range(0, 40);
        ax1 = $urandom_range(0, 40);
        ay1 = $urandom_range(0, 40);
      end else begin
        ax0 = $urandom_range(0, 255);
        ay0 = $urandom_range(0, 127);
        ax1 = $urandom_range(0, 255);
        ay1 = $urandom_range(0, 127);
      end
      run_line(ax0, ay0, ax1, ay1, $urandom_range(0, 63), $urandom_range(0, 2),
               ($urandom_range(0, 3) == 0), 0);
    end

    repeat (4) sync();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
